pixel_streamer: RTL and testbench
=================================

PIXEL_STREAMER -- requirements
Module: pixel_streamer

Interface
REQ-001 Parameter WIDTH, default 8, pixel width in bits.
REQ-002 Parameter IMG_W, default 28, image width in pixels.
REQ-003 Parameter IMG_H, default 28, image height in pixels.
REQ-004 Parameter ADDR_W, default 10, memory address width; SHALL satisfy 2**ADDR_W >= IMG_W*IMG_H.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 start  input  1  single-cycle request to stream one frame.
REQ-008 ready  input  1  downstream line buffer accepts a pixel this cycle.
REQ-009 mem_rd_en  output  1  image memory read strobe.
REQ-010 mem_addr  output  ADDR_W  image memory read address, row-major.
REQ-011 mem_rdata  input  WIDTH  read data; valid exactly one cycle after mem_rd_en.
REQ-012 dout  output  WIDTH  pixel to the line buffer din.
REQ-013 shift_en  output  1  pixel transfer strobe to the line buffer shift_en.
REQ-014 win_valid  output  1  the transferred pixel completes a valid 3x3 window.
REQ-015 busy  output  1  frame in progress.
REQ-016 done  output  1  one-cycle pulse at frame end.

Function
REQ-017 FSM states: IDLE, FETCH, WAIT, EMIT, DONE.
REQ-018 IDLE: start=1 -> FETCH next cycle, with row=col=0; start is ignored in every other state.
REQ-019 FETCH: mem_rd_en=1, mem_addr=row*IMG_W+col -> WAIT.
REQ-020 WAIT: pixel register loads mem_rdata at the end of the cycle -> EMIT.
REQ-021 EMIT: dout=pixel register; shift_en=ready; win_valid=ready AND row>=2 AND col>=2.
REQ-022 EMIT with ready=0: stay in EMIT; dout held; no strobe; counters held.
REQ-023 EMIT with ready=1: col increments; at col=IMG_W-1, col wraps to 0 and row increments; the last pixel goes to DONE, all others go to FETCH.
REQ-024 DONE: done=1 for one cycle -> IDLE.
REQ-025 busy=1 in FETCH, WAIT, EMIT and DONE.
REQ-026 Unstalled throughput: one pixel per 3 cycles; exactly IMG_W*IMG_H shift_en pulses per frame.
REQ-027 mem_addr SHALL be 0 whenever mem_rd_en=0.
REQ-028 shift_en and win_valid SHALL never assert outside EMIT.

Reset
REQ-029 rst=1 forces IDLE and clears row, col and the pixel register; dout, mem_addr, mem_rd_en, shift_en, win_valid, busy and done all read 0.
REQ-030 rst during a frame aborts it: no done pulse, and no further strobes until the next start.
REQ-031 rst has priority over start in the same cycle.

Configuration
REQ-032 Macro PIX_STREAM_PAD_EN.
- Defined: the streamed frame is (IMG_W+2)x(IMG_H+2) with a 1-pixel zero border.
- Defined, border positions: FETCH drives mem_rd_en=0, loads 0 into the pixel register and goes directly to EMIT, skipping WAIT.
- Defined, interior position (r,c): reads address (r-1)*IMG_W+(c-1).
- Defined: row, col and the win_valid rule use padded coordinates.
- Undefined: behaviour is as specified in REQ-017 to REQ-028.

Structure
REQ-033 Package pix_stream_pkg SHALL hold the FSM state typedef and the default IMG_W, IMG_H and WIDTH constants.
REQ-034 Sub-module raster_counter SHALL hold the row/col counters.
- Inputs: clear, advance.
- Outputs: row, col, last.
REQ-035 raster_counter SHALL be reused by the downstream window logic.

Verification
REQ-036 Unpadded frame, ready=1:
- 784 shift_en pulses and 784 reads.
- mem_addr sequence 0..783.
- 676 win_valid pulses; the first is on the 59th pulse (address 58).
- done pulses once, one cycle after the final EMIT.
REQ-037 Backpressure: ready=0 for 5 cycles in EMIT of pixel 10.
- dout is held at mem[10] throughout.
- No strobe is issued and no read is issued.
- Frame completes with exactly 784 pulses.
REQ-038 Reset at pixel 100:
- All outputs read 0 the next cycle and no done pulse occurs.
- A new start restarts from address 0.
REQ-039 Start while busy: a start pulse at pixel 300 has no effect; the frame completes as a single frame with one done.
REQ-040 PIX_STREAM_PAD_EN defined:
- 900 shift_en pulses, 784 reads and 116 zero pixels.
- 784 win_valid pulses; the first is on the 63rd pulse.
REQ-041 Random ready at 50% duty over 3 frames: the pixel order into a 26-deep shift-register model matches a golden row-major image.

Source files
------------

// File: rtl/pix_stream_pkg.sv
// Shared types and default geometry for the pixel streamer.
// Holds the FSM state encoding and default image/pixel sizes.
package pix_stream_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/raster_counter.sv
// Row-major raster position counter, shared with downstream window logic.
// clear restarts at (0,0); advance steps one pixel; last flags the final pixel.
module raster_counter #(
  parameter int COLS = 28,
  parameter int ROWS = 28,
  parameter int CW   = 5,
  parameter int RW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  logic [RW-1:0] row_q;
  logic [RW-1:0] row_d;
  logic [CW-1:0] col_q;
  logic [CW-1:0] col_d;
  logic          col_end;
  logic          row_end;

  assign col_end = (col_q == CW'(COLS - 1));
  assign row_end = (row_q == RW'(ROWS - 1));
  assign last    = col_end && row_end;
  assign row     = row_q;
  assign col     = col_q;

  // next position: column steps, wraps into the next row, frame wraps to 0
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // position registers
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/pixel_streamer.sv
// Streams one image frame from memory into a 3x3 line buffer.
// Optional macro PIX_STREAM_PAD_EN adds a one-pixel zero border.
module pixel_streamer
  import pix_stream_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ready,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [WIDTH-1:0]  dout,
  output logic              shift_en,
  output logic              win_valid,
  output logic              busy,
  output logic              done
);

`ifdef PIX_STREAM_PAD_EN
  localparam int PW = IMG_W + 2;
  localparam int PH = IMG_H + 2;
`else
  localparam int PW = IMG_W;
  localparam int PH = IMG_H;
`endif
  localparam int CW = $clog2(PW + 1);
  localparam int RW = $clog2(PH + 1);

  state_t            state_q;
  state_t            state_d;
  logic [WIDTH-1:0]  pix_q;
  logic [WIDTH-1:0]  pix_d;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic              last;
  logic              clear;
  logic              advance;
  logic              win_pos;
  logic [ADDR_W-1:0] rd_addr;

  raster_counter #(
    .COLS (PW),
    .ROWS (PH),
    .CW   (CW),
    .RW   (RW)
  ) u_raster (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .advance (advance),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  assign win_pos = (row >= RW'(2)) && (col >= CW'(2));

`ifdef PIX_STREAM_PAD_EN
  logic border;
  assign border = (row == '0) || (row == RW'(PH - 1))
               || (col == '0) || (col == CW'(PW - 1));
  assign rd_addr = (ADDR_W'(row) - ADDR_W'(1)) * ADDR_W'(IMG_W)
                 + ADDR_W'(col) - ADDR_W'(1);
`else
  assign rd_addr = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
`endif

  // frame sequencer: next state, pixel capture and all strobes
  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    dout      = '0;
    shift_en  = 1'b0;
    win_valid = 1'b0;
    done      = 1'b0;
    clear     = 1'b0;
    advance   = 1'b0;
    busy      = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
`ifdef PIX_STREAM_PAD_EN
        if (border) begin
          pix_d   = '0;
          state_d = EMIT;
        end else begin
          mem_rd_en = 1'b1;
          mem_addr  = rd_addr;
          state_d   = WAIT;
        end
`else
        mem_rd_en = 1'b1;
        mem_addr  = rd_addr;
        state_d   = WAIT;
`endif
      end
      WAIT: begin
        pix_d   = mem_rdata;
        state_d = EMIT;
      end
      EMIT: begin
        dout      = pix_q;
        shift_en  = ready;
        win_valid = ready && win_pos;
        if (ready) begin
          advance = 1'b1;
          state_d = last ? DONE : FETCH;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and pixel registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
    end
  end

endmodule

// File: tb/tb_pixel_streamer.sv
// Self-checking bench for pixel_streamer.
// Cycle vectors plus frame-level sequences checked by a monitor.
`timescale 1ns/1ps
module tb_pixel_streamer;

`ifdef PIX_STREAM_PAD_EN
  localparam int PW    = 30;
  localparam int PH    = 30;
  localparam int TOT   = 900;
  localparam int WIN   = 784;
  localparam int FIRST = 63;
  localparam int ZERO  = 116;
`else
  localparam int PW    = 28;
  localparam int PH    = 28;
  localparam int TOT   = 784;
  localparam int WIN   = 676;
  localparam int FIRST = 59;
  localparam int ZERO  = 0;
`endif
  localparam int RD = 784;

  logic       clk = 0;
  logic       rst = 1;
  logic       start = 0;
  logic       ready = 0;
  logic       mem_rd_en;
  logic [9:0] mem_addr;
  logic [7:0] mem_rdata = 0;
  logic [7:0] dout;
  logic       shift_en;
  logic       win_valid;
  logic       busy;
  logic       done;

  int total = 0;
  int passed = 0;

  int shift_cnt, rd_cnt, win_cnt, first_win, done_cnt, zero_cnt;
  int addr_err, addr0_err, pix_err, win_err, done_err;
  bit last_prev;

  pixel_streamer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ready     (ready),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .dout      (dout),
    .shift_en  (shift_en),
    .win_valid (win_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_f(input int a);
    int v;
    v = a * 37 + 5;
    return 8'(v) | 8'h01;
  endfunction

  function automatic logic [7:0] gold(input int r, input int c);
`ifdef PIX_STREAM_PAD_EN
    if (r == 0 || r == PH - 1 || c == 0 || c == PW - 1) return 8'h00;
    return mem_f((r - 1) * 28 + c - 1);
`else
    return mem_f(r * 28 + c);
`endif
  endfunction

  always @(posedge clk)
    if (mem_rd_en) mem_rdata <= mem_f(int'(mem_addr));

  always @(negedge clk) begin
    int idx, r, c;
    if (!mem_rd_en && mem_addr != 0) addr0_err++;
    if (win_valid && !shift_en) win_err++;
    if (mem_rd_en) begin
      if (int'(mem_addr) != rd_cnt % RD) addr_err++;
      rd_cnt++;
    end
    if (done) begin
      done_cnt++;
      if (!last_prev) done_err++;
    end
    last_prev = 0;
    if (shift_en) begin
      idx = shift_cnt % TOT;
      r = idx / PW;
      c = idx % PW;
      if (dout != gold(r, c)) pix_err++;
      if (dout == 0) zero_cnt++;
      if (win_valid != (r >= 2 && c >= 2)) win_err++;
      if (win_valid) begin
        win_cnt++;
        if (first_win == 0) first_win = shift_cnt + 1;
      end
      last_prev = (idx == TOT - 1);
      shift_cnt++;
    end
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
  endtask

  task automatic clr_mon();
    shift_cnt = 0; rd_cnt = 0; win_cnt = 0; first_win = 0;
    done_cnt = 0; zero_cnt = 0; addr_err = 0; addr0_err = 0;
    pix_err = 0; win_err = 0; done_err = 0; last_prev = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, input string nm);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1;
      if (rnd) ready = 1'($urandom_range(1, 0));
      @(negedge clk); #1;
      n++;
    end
    chk({nm, "_done_seen"}, done_cnt != d0, 1);
    ready = 1;
  endtask

  task automatic wait_shift(input int n, input string nm);
    int k;
    k = 0;
    while (shift_cnt < n && k < 5000) begin
      @(negedge clk); #1;
      k++;
    end
    chk({nm, "_reach"}, shift_cnt >= n, 1);
  endtask

  typedef struct {
    int rst, start, ready;
    int busy, rd, addr, dout, sh, win, dn;
  } vec_t;

  initial begin
    vec_t v[15];
    clr_mon();
    repeat (3) @(posedge clk);

`ifndef PIX_STREAM_PAD_EN
    v[0]  = '{1, 0, 0,  0, 0, 0,  0, 0, 0, 0};
    v[1]  = '{0, 1, 0,  0, 0, 0,  0, 0, 0, 0};
    v[2]  = '{0, 0, 0,  1, 1, 0,  0, 0, 0, 0};
    v[3]  = '{0, 0, 0,  1, 0, 0,  0, 0, 0, 0};
    v[4]  = '{0, 0, 0,  1, 0, 0,  5, 0, 0, 0};
    v[5]  = '{0, 0, 1,  1, 0, 0,  5, 1, 0, 0};
    v[6]  = '{0, 1, 1,  1, 1, 1,  0, 0, 0, 0};
    v[7]  = '{0, 0, 1,  1, 0, 0,  0, 0, 0, 0};
    v[8]  = '{0, 0, 1,  1, 0, 0, 43, 1, 0, 0};
    v[9]  = '{1, 0, 1,  1, 1, 2,  0, 0, 0, 0};
    v[10] = '{0, 0, 1,  0, 0, 0,  0, 0, 0, 0};
    v[11] = '{0, 1, 1,  0, 0, 0,  0, 0, 0, 0};
    v[12] = '{0, 0, 1,  1, 1, 0,  0, 0, 0, 0};
    v[13] = '{1, 0, 1,  1, 0, 0,  0, 0, 0, 0};
    v[14] = '{0, 0, 0,  0, 0, 0,  0, 0, 0, 0};
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      rst = v[i].rst[0];
      start = v[i].start[0];
      ready = v[i].ready[0];
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {busy, mem_rd_en, mem_addr, dout, shift_en, win_valid, done},
          {v[i].busy[0], v[i].rd[0], 10'(v[i].addr), 8'(v[i].dout),
           v[i].sh[0], v[i].win[0], v[i].dn[0]});
    end
`endif

    // full frame, ready high
    @(posedge clk); #1 rst = 1; ready = 1; start = 0;
    @(posedge clk); #1 rst = 0;
    clr_mon();
    pulse_start();
    wait_done(4000, 0, "frame");
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    chk("frame_shifts", shift_cnt, TOT);
    chk("frame_reads", rd_cnt, RD);
    chk("frame_addr_seq", addr_err, 0);
    chk("frame_addr_idle0", addr0_err, 0);
    chk("frame_pixels", pix_err, 0);
    chk("frame_zeros", zero_cnt, ZERO);
    chk("frame_wins", win_cnt, WIN);
    chk("frame_first_win", first_win, FIRST);
    chk("frame_win_rule", win_err, 0);
    chk("frame_done_cnt", done_cnt, 1);
    chk("frame_done_time", done_err, 0);
    chk("frame_idle_busy", busy, 0);

`ifndef PIX_STREAM_PAD_EN
    // backpressure on pixel 10
    clr_mon();
    pulse_start();
    wait_shift(10, "bp");
    @(posedge clk); #1 ready = 0;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp_hold%0d", k),
          {dout, shift_en, mem_rd_en}, {mem_f(10), 1'b0, 1'b0});
    end
    @(posedge clk); #1 ready = 1;
    wait_done(4000, 0, "bp");
    chk("bp_shifts", shift_cnt, 784);
    chk("bp_pixels", pix_err, 0);
    chk("bp_reads", rd_cnt, 784);

    // reset mid-frame at pixel 100
    clr_mon();
    pulse_start();
    wait_shift(100, "rst");
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_outputs_zero",
        {dout, mem_addr, mem_rd_en, shift_en, win_valid, busy, done}, 0);
    begin
      int sc;
      sc = shift_cnt;
      repeat (30) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_no_strobe", shift_cnt, sc);
      chk("rst_no_done", done_cnt, 0);
    end
    clr_mon();
    pulse_start();
    wait_done(4000, 0, "restart");
    chk("restart_addr_seq", addr_err, 0);
    chk("restart_shifts", shift_cnt, 784);

    // start pulse while busy
    clr_mon();
    pulse_start();
    wait_shift(300, "busy");
    pulse_start();
    wait_done(4000, 0, "busy");
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    chk("busy_done_cnt", done_cnt, 1);
    chk("busy_shifts", shift_cnt, 784);
    chk("busy_idle", busy, 0);
`endif

    // random ready over three frames
    clr_mon();
    for (int f = 0; f < 3; f++) begin
      pulse_start();
      wait_done(12000, 1, $sformatf("rnd%0d", f));
      @(posedge clk); #1;
    end
    chk("rnd_shifts", shift_cnt, 3 * TOT);
    chk("rnd_order", pix_err, 0);
    chk("rnd_done_cnt", done_cnt, 3);
    chk("rnd_win_rule", win_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
